int_to_7_digit: RTL and testbench

- Converts a 32-bit signed integer into seven BCD digits for on-screen HUD rendering (score, level).
- Sits between game-state counters and the HUD pixel renderer, which reads digits every pixel clock combinationally.
- Conversion is sequential (shift-add-3 "double dabble"). Output digits update atomically once per conversion pass, so the renderer never sees partial results.

---
 rtl/int_to_7_digit_if.sv | 9 +
 rtl/int_to_7_digit.sv | 72 +++++++
 tb/tb_int_to_7_digit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/int_to_7_digit_if.sv
// Value/digit bundle between game-state counters and the HUD renderer.
// The producer drives number and reads digits; the converter does the opposite.
interface int_to_7_digit_if;
  int          number;
  logic [3:0]  digits [7];

  modport master (output number, input digits);
  modport slave  (input number, output digits);
endinterface

// File: rtl/int_to_7_digit.sv
// Free-running double-dabble converter: signed int -> seven BCD digits.
// The whole digit set is published in one cycle per 26-cycle pass, so readers never see a partial result.
module int_to_7_digit (
  input  logic             clk,
  input  logic             reset,
  int_to_7_digit_if.slave  bus
);
  localparam int N_DIGITS = 7;
  localparam int BIN_W    = 24;
  localparam int BCD_W    = 4 * N_DIGITS;
  localparam int MAX_VAL  = 9999999;

  typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   digits_q;
  logic [4:0]         cnt_q;

  logic [BIN_W-1:0]   cond_d;
  logic [BCD_W-1:0]   bcd_adj_d;

  // Clamp to [0, MAX_VAL]; the saturation ceiling keeps the result inside seven digits.
  always_comb begin
    cond_d = '0;
    if (bus.number < 0)
      cond_d = '0;
    else if (bus.number > MAX_VAL)
      cond_d = BIN_W'(MAX_VAL);
    else
      cond_d = bus.number[BIN_W-1:0];
  end

  // Per-nibble add-3 before each shift; corrections never carry across nibbles.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nibble
    assign bcd_adj_d[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                           : bcd_q[gi*4 +: 4];
    assign bus.digits[gi] = digits_q[gi*4 +: 4];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      bin_q    <= '0;
      bcd_q    <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          bin_q   <= cond_d;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= {bcd_adj_d[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(BIN_W - 1))
            state_q <= DONE;
        end
        DONE: begin
          digits_q <= bcd_q;
          state_q  <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_int_to_7_digit.sv
// Randomized and directed checks of int_to_7_digit against a decimal-arithmetic reference.
module tb_int_to_7_digit;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [27:0] dut_digits;

  int_to_7_digit_if bus ();

  int_to_7_digit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 7; gi++) begin : g_pack
    assign dut_digits[gi*4 +: 4] = bus.digits[gi];
  end

  function automatic logic [27:0] ref_digits(input int n);
    longint v;
    logic [27:0] r;
    v = n;
    if (v < 0) v = 0;
    if (v > 9999999) v = 9999999;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_and_check(input string tag, input int val);
    bus.number = val;
    edges(52);
    check(tag, dut_digits, ref_digits(val));
    $display("%s: number=%0d digits=%h", tag, val, dut_digits);
  endtask

  initial begin
    int  seen;
    int  lat;
    int  val;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.number = 1234;

    for (int k = 0; k < 4; k++) begin
      edges(10);
      check("rst_hold", dut_digits, 28'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    edges(27);
    check("rst_release", dut_digits, ref_digits(1234));
    $display("rst_release: digits=%h", dut_digits);

    apply_and_check("zero", 0);
    apply_and_check("max", 9999999);
    apply_and_check("ten", 10);
    apply_and_check("neg", -5);
    apply_and_check("sat", 12345678);
    apply_and_check("int_min", 32'sh8000_0000);
    apply_and_check("int_max", 32'sh7fff_ffff);

    // Steady input: output must not move across three passes.
    bus.number = 1000000;
    edges(52);
    for (int k = 0; k < 78; k++) begin
      edges(1);
      check("steady", dut_digits, ref_digits(1000000));
    end
    $display("steady: digits=%h", dut_digits);

    // Atomic switch 42 -> 7 with bounded latency.
    bus.number = 42;
    edges(52);
    check("chg_pre", dut_digits, ref_digits(42));
    edges($urandom_range(0, 25));
    bus.number = 7;
    seen = 0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      edges(1);
      if (seen == 0 && dut_digits == ref_digits(7)) begin
        seen = 1;
        lat = k;
      end
      check("chg_val", dut_digits, (seen != 0) ? ref_digits(7) : ref_digits(42));
    end
    check("chg_lat", {27'd0, (seen != 0 && lat <= 51)}, 28'd1);
    $display("chg: 42->7 latency=%0d", lat);

    // Exact latency from reset release, then async reset mid-SHIFT.
    bus.number = 555;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_async0", dut_digits, 28'd0);
    @(negedge clk);
    reset = 1'b1;
    edges(25);
    check("lat_25", dut_digits, 28'd0);
    edges(1);
    check("lat_26", dut_digits, ref_digits(555));
    edges(6);
    #2;
    reset = 1'b0;
    #1;
    check("rst_midshift", dut_digits, 28'd0);
    edges(2);
    @(negedge clk);
    reset = 1'b1;
    edges(25);
    check("rst_mid_25", dut_digits, 28'd0);
    edges(1);
    check("rst_mid_26", dut_digits, ref_digits(555));
    $display("rst_mid: digits=%h", dut_digits);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0:       val = int'($urandom_range(0, 9999999));
        1:       val = int'($urandom);
        default: val = -int'($urandom_range(1, 1000000));
      endcase
      apply_and_check("rand", val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
